// File: rtl/pss_pkg.sv
// pss_pkg - shared constants, types and index helpers for the PSS generator.
//
// Holds the m-sequence definition (length, 7-bit LFSR seed and feedback
// taps), the N_id_2 cyclic-shift constants and the generator state type.
// The index helpers replace the multiply and modulo in the symbol mapping
// with a 3-entry lookup, because N_id_2 only takes the values 0..2.

package pss_pkg;

  localparam int PSS_SEQ_LEN  = 127;
  localparam int NID2_SHIFT   = 43;
  localparam int PSS_K_OFFSET = 64;

  // Seed bit j holds x(j): x0=0 x1=1 x2=1 x3=0 x4=1 x5=1 x6=1
  localparam logic [6:0] LFSR_INIT   = 7'b1110110;
  localparam int         LFSR_TAP_HI = 4;
  localparam int         LFSR_TAP_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    OUT  = 2'd2
  } pss_state_e;

  typedef logic [6:0] seq_idx_t;

  // Sequence index used by the first negative subcarrier (k = -64)
  function automatic seq_idx_t nid2_base_idx(input logic [1:0] nid2);
    seq_idx_t idx;
    case (nid2)
      2'd1:    idx = seq_idx_t'(NID2_SHIFT % PSS_SEQ_LEN);
      2'd2:    idx = seq_idx_t'((2 * NID2_SHIFT) % PSS_SEQ_LEN);
      default: idx = seq_idx_t'(0);
    endcase
    return idx;
  endfunction

  // Sequence index used by bin 0 (k = 0)
  function automatic seq_idx_t nid2_start_idx(input logic [1:0] nid2);
    seq_idx_t idx;
    case (nid2)
      2'd1:    idx = seq_idx_t'((PSS_K_OFFSET + NID2_SHIFT) % PSS_SEQ_LEN);
      2'd2:    idx = seq_idx_t'((PSS_K_OFFSET + 2 * NID2_SHIFT) % PSS_SEQ_LEN);
      default: idx = seq_idx_t'(PSS_K_OFFSET % PSS_SEQ_LEN);
    endcase
    return idx;
  endfunction

  function automatic seq_idx_t seq_idx_inc(input seq_idx_t m);
    return (m == seq_idx_t'(PSS_SEQ_LEN - 1)) ? seq_idx_t'(0) : m + seq_idx_t'(1);
  endfunction

endpackage

// File: rtl/pss_freq_gen_if.sv
// pss_freq_gen_if - config and sample streams of the PSS generator.
//
// Signals:
//   s_axis_cfg_tdata/tvalid/tready  config stream carrying N_id_2 (2 bits)
//   m_axis_out_tdata/tvalid/tready/tlast  frequency-domain sample stream,
//                                         tdata = {im, re}, OUT_DW bits
// Modports:
//   slave  - the generator (consumes config, produces samples)
//   master - the environment (produces config, consumes samples)

interface pss_freq_gen_if #(
  parameter int OUT_DW = 32
);

  logic [1:0]        s_axis_cfg_tdata;
  logic              s_axis_cfg_tvalid;
  logic              s_axis_cfg_tready;
  logic [OUT_DW-1:0] m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic              m_axis_out_tready;
  logic              m_axis_out_tlast;

  modport slave (
    input  s_axis_cfg_tdata,
    input  s_axis_cfg_tvalid,
    output s_axis_cfg_tready,
    output m_axis_out_tdata,
    output m_axis_out_tvalid,
    input  m_axis_out_tready,
    output m_axis_out_tlast
  );

  modport master (
    output s_axis_cfg_tdata,
    output s_axis_cfg_tvalid,
    input  s_axis_cfg_tready,
    input  m_axis_out_tdata,
    input  m_axis_out_tvalid,
    output m_axis_out_tready,
    input  m_axis_out_tlast
  );

endinterface

// File: rtl/pss_mseq_lfsr.sv
// pss_mseq_lfsr - 7-bit Fibonacci LFSR for the PSS m-sequence,
// x(i+7) = x(i+4) XOR x(i). Kept standalone so the SSS generator can reuse it.
//
// Ports:
//   clk_i     clock
//   reset_ni  synchronous active-low reset (reloads the seed)
//   load      reload the seed; bit_o then presents x(0)
//   step      advance one position in the sequence
//   bit_o     current sequence bit x(i)

module pss_mseq_lfsr
  import pss_pkg::*;
(
  input  logic clk_i,
  input  logic reset_ni,
  input  logic load,
  input  logic step,
  output logic bit_o
);

  // Bit j of the register holds x(i+j); the new x(i+7) enters at the top.
  logic [6:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      lfsr_q <= LFSR_INIT;
    end else if (load) begin
      lfsr_q <= LFSR_INIT;
    end else if (step) begin
      lfsr_q <= {lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO], lfsr_q[6:1]};
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/pss_freq_gen.sv
// pss_freq_gen - frequency-domain PSS source.
//
// A config beat carrying N_id_2 (0..2) starts a 127-cycle m-sequence
// generation pass, after which one OFDM symbol of FFT_LEN samples is
// streamed in FFT bin order. The 127 BPSK symbols sit on subcarriers
// k = -64..62 (re = +/-AMP, im = 0); every other bin is zero.
// N_id_2 = 3 is rejected with a one-cycle err_o pulse.
//
// Optional build macro PSS_GEN_REPEAT_EN: the symbol repeats back to back
// after each tlast; a new config is only taken in the tlast beat.
//
// Ports:
//   clk_i     clock
//   reset_ni  synchronous active-low reset
//   bus       pss_freq_gen_if.slave (config in, samples out)
//   err_o     pulse on an invalid N_id_2 config

module pss_freq_gen
  import pss_pkg::*;
#(
  parameter int OUT_DW  = 32,
  parameter int FFT_LEN = 256,
  parameter int AMP     = 8192
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  pss_freq_gen_if.slave   bus,
  output logic            err_o
);

  localparam int HW    = OUT_DW / 2;
  localparam int BIN_W = $clog2(FFT_LEN);

  localparam logic signed [HW-1:0] RE_POS = HW'(AMP);
  localparam logic signed [HW-1:0] RE_NEG = HW'(-AMP);

  localparam logic [BIN_W-1:0] BIN_LAST      = BIN_W'(FFT_LEN - 1);
  localparam logic [BIN_W-1:0] BIN_POS_LAST  = BIN_W'(PSS_SEQ_LEN - PSS_K_OFFSET - 1);
  localparam logic [BIN_W-1:0] BIN_NEG_FIRST = BIN_W'(FFT_LEN - PSS_K_OFFSET);

  if (AMP >= 2 ** (HW - 1)) begin : g_amp_check
    $error("pss_freq_gen: AMP does not fit in a signed OUT_DW/2 field");
  end
  if (FFT_LEN < 128 || (FFT_LEN & (FFT_LEN - 1)) != 0) begin : g_fft_check
    $error("pss_freq_gen: FFT_LEN must be a power of two >= 128");
  end

  pss_state_e            state_q;
  logic [1:0]            nid2_q;
  logic [PSS_SEQ_LEN-1:0] seq_q;
  logic [6:0]            gen_cnt_q;
  logic [BIN_W-1:0]      bin_q;
  seq_idx_t              m_q;
  logic [OUT_DW-1:0]     tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  cfg_rdy_q;
  logic                  err_q;

  logic                   lfsr_bit;
  logic                   cfg_hs;
  logic                   out_hs;
  logic                   start_gen;
  logic                   gen_done;
  logic [PSS_SEQ_LEN-1:0] seq_shift;

  logic [BIN_W-1:0]       nxt_bin;
  seq_idx_t               nxt_m;
  logic [PSS_SEQ_LEN-1:0] nxt_src;
  logic                   nxt_in_band;
  logic signed [HW-1:0]   nxt_re;
  logic [OUT_DW-1:0]      nxt_data;
  logic                   nxt_last;

  pss_mseq_lfsr u_lfsr (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load     (start_gen),
    .step     (state_q == GEN),
    .bit_o    (lfsr_bit)
  );

`ifdef PSS_GEN_REPEAT_EN
  // A new config may only slip in on the beat that closes a symbol.
  assign bus.s_axis_cfg_tready = cfg_rdy_q | ((state_q == OUT) & out_hs & tlast_q);
`else
  assign bus.s_axis_cfg_tready = cfg_rdy_q;
`endif

  assign cfg_hs    = bus.s_axis_cfg_tvalid & bus.s_axis_cfg_tready;
  assign out_hs    = tvalid_q & bus.m_axis_out_tready;
  assign start_gen = cfg_hs & (bus.s_axis_cfg_tdata != 2'd3);
  assign gen_done  = (state_q == GEN) && (gen_cnt_q == 7'(PSS_SEQ_LEN - 1));
  // seq fills from the top; after 127 shifts seq[j] = x(j)
  assign seq_shift = {lfsr_bit, seq_q[PSS_SEQ_LEN-1:1]};

  // Next sample to present. Bin 0 is reached either from the end of GEN
  // (the final sequence bit is still in flight, so read the shifted copy)
  // or by wrapping after tlast in repeat mode.
  always_comb begin
    nxt_bin = bin_q + BIN_W'(1);
    nxt_m   = m_q;
    nxt_src = seq_q;
    if (state_q != OUT || tlast_q) begin
      nxt_bin = '0;
      nxt_m   = nid2_start_idx(nid2_q);
      if (state_q == GEN) begin
        nxt_src = seq_shift;
      end
    end else if (nxt_bin == BIN_NEG_FIRST) begin
      nxt_m = nid2_base_idx(nid2_q);
    end else if (nxt_bin <= BIN_POS_LAST || nxt_bin > BIN_NEG_FIRST) begin
      nxt_m = seq_idx_inc(m_q);
    end
    nxt_in_band = (nxt_bin <= BIN_POS_LAST) || (nxt_bin >= BIN_NEG_FIRST);
    if (!nxt_in_band) begin
      nxt_re = '0;
    end else if (nxt_src[nxt_m]) begin
      nxt_re = RE_NEG;
    end else begin
      nxt_re = RE_POS;
    end
    nxt_data = {{HW{1'b0}}, nxt_re};
    nxt_last = (nxt_bin == BIN_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      nid2_q    <= '0;
      seq_q     <= '0;
      gen_cnt_q <= '0;
      bin_q     <= '0;
      m_q       <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      cfg_rdy_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_hs) begin
            if (bus.s_axis_cfg_tdata == 2'd3) begin
              err_q <= 1'b1;
            end else begin
              nid2_q    <= bus.s_axis_cfg_tdata;
              gen_cnt_q <= '0;
              cfg_rdy_q <= 1'b0;
              state_q   <= GEN;
            end
          end
        end
        GEN: begin
          seq_q     <= seq_shift;
          gen_cnt_q <= gen_cnt_q + 7'd1;
          if (gen_done) begin
            state_q  <= OUT;
            bin_q    <= nxt_bin;
            m_q      <= nxt_m;
            tdata_q  <= nxt_data;
            tlast_q  <= nxt_last;
            tvalid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_hs) begin
            bin_q   <= nxt_bin;
            m_q     <= nxt_m;
            tdata_q <= nxt_data;
            tlast_q <= nxt_last;
            if (tlast_q) begin
`ifdef PSS_GEN_REPEAT_EN
              if (cfg_hs) begin
                if (bus.s_axis_cfg_tdata == 2'd3) begin
                  err_q <= 1'b1;
                end else begin
                  nid2_q    <= bus.s_axis_cfg_tdata;
                  gen_cnt_q <= '0;
                  state_q   <= GEN;
                  tvalid_q  <= 1'b0;
                  tdata_q   <= '0;
                  tlast_q   <= 1'b0;
                end
              end
`else
              state_q   <= IDLE;
              tvalid_q  <= 1'b0;
              tdata_q   <= '0;
              tlast_q   <= 1'b0;
              cfg_rdy_q <= 1'b1;
`endif
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_axis_out_tdata  = tdata_q;
  assign bus.m_axis_out_tvalid = tvalid_q;
  assign bus.m_axis_out_tlast  = tlast_q;
  assign err_o                 = err_q;

endmodule
